// File: rtl/bsg_manycore_wh_edge_concentrator_if.sv
// Link bundle of the edge concentrator: lane-side links plus the single edge-side link.
// Each link is a packed {v, data, ready_and_rev} word.
interface bsg_manycore_wh_edge_concentrator_if #(
  parameter int wh_flit_width_p = 16,
  parameter int num_in_p        = 2
);
  localparam int wh_link_sif_width_lp = wh_flit_width_p + 2;

  logic [num_in_p-1:0][wh_link_sif_width_lp-1:0] links_i;
  logic [num_in_p-1:0][wh_link_sif_width_lp-1:0] links_o;
  logic [wh_link_sif_width_lp-1:0]               concentrated_link_i;
  logic [wh_link_sif_width_lp-1:0]               concentrated_link_o;

  modport master (
    output links_i,
    output concentrated_link_i,
    input  links_o,
    input  concentrated_link_o
  );

  modport slave (
    input  links_i,
    input  concentrated_link_i,
    output links_o,
    output concentrated_link_o
  );
endinterface

// File: rtl/bsg_manycore_wh_edge_concentrator.sv
// Edge concentrator: merges num_in_p vcache wormhole lanes into one link and
// steers returning packets back to their lane using the header cid.

module bsg_manycore_wh_edge_concentrator_fifo #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  logic [1:0][width_p-1:0] r_mem;
  logic                    r_wPtr;
  logic                    r_rPtr;
  logic [1:0]              r_count;
  logic                    w_enq;
  logic                    w_deq;

  // Ready depends only on occupancy, so no ready-to-ready path crosses the block
  assign ready_o = ~reset_i & (r_count != 2'd2);
  assign v_o     = (r_count != 2'd0);
  assign data_o  = r_mem[r_rPtr];
  assign w_enq   = v_i & ready_o;
  assign w_deq   = yumi_i & v_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_mem   <= '0;
      r_wPtr  <= 1'b0;
      r_rPtr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_enq) begin
        r_mem[r_wPtr] <= data_i;
        r_wPtr        <= ~r_wPtr;
      end
      if (w_deq) r_rPtr <= ~r_rPtr;
      r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
    end
  end
endmodule

module bsg_manycore_wh_edge_concentrator #(
  parameter int wh_flit_width_p = 16,
  parameter int wh_cid_width_p  = 4,
  parameter int wh_len_width_p  = 4,
  parameter int wh_cord_width_p = 4,
  parameter int num_in_p        = 2
) (
  input logic clk_i,
  input logic reset_i,
  bsg_manycore_wh_edge_concentrator_if.slave link_if
);
  localparam int lg_num_in_lp         = (num_in_p > 1) ? $clog2(num_in_p) : 1;
  localparam int wh_link_sif_width_lp = wh_flit_width_p + 2;
  localparam int lenLsb_lp            = wh_cord_width_p;
  localparam int cidLsb_lp            = wh_cord_width_p + wh_len_width_p;

  typedef enum logic {IDLE, BUSY} state_e;

  logic [num_in_p-1:0]                            w_laneV;
  logic [num_in_p-1:0]                            w_laneReady;
  logic [num_in_p-1:0]                            w_laneYumi;
  logic [num_in_p-1:0][wh_flit_width_p-1:0]       w_laneData;
  logic [num_in_p-1:0][wh_link_sif_width_lp-1:0]  w_linksO;

  state_e                    r_fwdState, w_fwdNext;
  logic [wh_len_width_p-1:0] r_fwdCnt;
  logic [lg_num_in_lp-1:0]   r_fwdLane;
  logic [lg_num_in_lp-1:0]   r_rrPtr;
  logic                      r_fwdHold;
  logic [lg_num_in_lp-1:0]   w_arbLane;
  logic                      w_arbFound;
  logic [lg_num_in_lp-1:0]   w_fwdLane;
  logic [lg_num_in_lp-1:0]   w_rrNext;
  logic                      w_fwdV;
  logic [wh_flit_width_p-1:0] w_fwdData;
  logic [wh_len_width_p-1:0] w_fwdLen;
  logic                      w_fwdXfer;

  state_e                    r_retState, w_retNext;
  logic [wh_len_width_p-1:0] r_retCnt;
  logic [lg_num_in_lp-1:0]   r_retLane;
  logic                      w_retV;
  logic                      w_retReady;
  logic [wh_flit_width_p-1:0] w_retData;
  logic [wh_len_width_p-1:0] w_retLen;
  logic [wh_cid_width_p-1:0] w_retCid;
  logic [lg_num_in_lp-1:0]   w_retLane;
  logic                      w_retXfer;

  for (genvar i = 0; i < num_in_p; i++) begin : g_lane
    bsg_manycore_wh_edge_concentrator_fifo #(.width_p(wh_flit_width_p)) laneFifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (link_if.links_i[i][wh_link_sif_width_lp-1]),
      .data_i  (link_if.links_i[i][wh_link_sif_width_lp-2:1]),
      .ready_o (w_laneReady[i]),
      .v_o     (w_laneV[i]),
      .data_o  (w_laneData[i]),
      .yumi_i  (w_laneYumi[i])
    );
  end

  bsg_manycore_wh_edge_concentrator_fifo #(.width_p(wh_flit_width_p)) retFifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (link_if.concentrated_link_i[wh_link_sif_width_lp-1]),
    .data_i  (link_if.concentrated_link_i[wh_link_sif_width_lp-2:1]),
    .ready_o (w_retReady),
    .v_o     (w_retV),
    .data_o  (w_retData),
    .yumi_i  (w_retXfer)
  );

  // Round-robin search begins at r_rrPtr, the lane after the last granted one
  always_comb begin
    w_arbLane  = '0;
    w_arbFound = 1'b0;
    for (int k = 0; k < num_in_p; k++) begin
      int idx;
      idx = (int'(r_rrPtr) + k) % num_in_p;
      if (!w_arbFound && w_laneV[lg_num_in_lp'(idx)]) begin
        w_arbFound = 1'b1;
        w_arbLane  = lg_num_in_lp'(idx);
      end
    end
  end

  assign w_fwdLane = (r_fwdState == BUSY || r_fwdHold) ? r_fwdLane : w_arbLane;
  assign w_fwdV    = w_laneV[w_fwdLane];
  assign w_fwdData = w_laneData[w_fwdLane];
  assign w_fwdLen  = w_fwdData[lenLsb_lp +: wh_len_width_p];
  assign w_fwdXfer = w_fwdV & link_if.concentrated_link_i[0];
  assign w_rrNext  = (int'(w_fwdLane) == num_in_p - 1) ? '0 : w_fwdLane + 1'b1;

  always_comb begin
    w_laneYumi = '0;
    w_laneYumi[w_fwdLane] = w_fwdXfer;
  end

  assign w_retCid  = w_retData[cidLsb_lp +: wh_cid_width_p];
  assign w_retLen  = w_retData[lenLsb_lp +: wh_len_width_p];
  assign w_retLane = (r_retState == BUSY) ? r_retLane : lg_num_in_lp'(w_retCid);
  assign w_retXfer = w_retV & link_if.links_i[w_retLane][0];

  always_comb begin
    w_linksO = '0;
    for (int i = 0; i < num_in_p; i++) begin
      w_linksO[i] = {w_retV && (int'(w_retLane) == i), w_retData, w_laneReady[i]};
    end
  end

  assign link_if.links_o             = w_linksO;
  assign link_if.concentrated_link_o = {w_fwdV, w_fwdData, w_retReady};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_fwdState <= IDLE;
      r_retState <= IDLE;
    end else begin
      r_fwdState <= w_fwdNext;
      r_retState <= w_retNext;
    end
  end

  // A header with len==0 is a whole packet, so only a nonzero len enters BUSY
  always_comb begin
    w_fwdNext = r_fwdState;
    w_retNext = r_retState;
    case (r_fwdState)
      IDLE:    if (w_fwdXfer && w_fwdLen != '0) w_fwdNext = BUSY;
      BUSY:    if (w_fwdXfer && r_fwdCnt == wh_len_width_p'(1)) w_fwdNext = IDLE;
      default: w_fwdNext = IDLE;
    endcase
    case (r_retState)
      IDLE:    if (w_retXfer && w_retLen != '0) w_retNext = BUSY;
      BUSY:    if (w_retXfer && r_retCnt == wh_len_width_p'(1)) w_retNext = IDLE;
      default: w_retNext = IDLE;
    endcase
  end

  // A stalled grant is pinned so a newly valid lane cannot steal the output
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_fwdCnt  <= '0;
      r_fwdLane <= '0;
      r_rrPtr   <= '0;
      r_fwdHold <= 1'b0;
    end else if (r_fwdState == IDLE) begin
      r_fwdHold <= w_fwdV & ~w_fwdXfer;
      if (w_fwdV) r_fwdLane <= w_fwdLane;
      if (w_fwdXfer) begin
        r_fwdCnt <= w_fwdLen;
        if (w_fwdLen == '0) r_rrPtr <= w_rrNext;
      end
    end else if (w_fwdXfer) begin
      r_fwdCnt <= r_fwdCnt - 1'b1;
      if (r_fwdCnt == wh_len_width_p'(1)) r_rrPtr <= w_rrNext;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_retCnt  <= '0;
      r_retLane <= '0;
    end else if (w_retXfer) begin
      if (r_retState == IDLE) begin
        r_retCnt  <= w_retLen;
        r_retLane <= w_retLane;
      end else begin
        r_retCnt  <= r_retCnt - 1'b1;
      end
    end
  end

  cidRange: assert property (@(posedge clk_i) disable iff (reset_i)
    (r_retState == IDLE && w_retV) |-> (int'(w_retCid) < num_in_p))
    else $error("return header cid %0d has no lane", w_retCid);
endmodule

// File: tb/tb_bsg_manycore_wh_edge_concentrator.sv
// Randomized scoreboard bench for the edge concentrator; a packet-level model
// predicts arbitration order and return steering.
module tb_bsg_manycore_wh_edge_concentrator;
  localparam int FW = 16, CIDW = 4, LENW = 4, CORDW = 4, N = 2, LW = FW + 2;

  typedef struct packed {
    logic [7:0]    lane;
    logic [FW-1:0] data;
  } retFlit_t;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [N-1:0]         fwdV = '0;
  logic [N-1:0][FW-1:0] fwdData = '0;
  logic [N-1:0]         retRdy = '0;
  logic                 retV = 1'b0;
  logic [FW-1:0]        retData = '0;
  logic                 concRdy = 1'b0;

  int fwdPct = 100, concPct = 100, retPct = 100, laneRdyPct = 100;
  int totalChecks = 0, passCount = 0;

  logic [FW-1:0] fwdSendQ [N][$];
  logic [FW-1:0] laneQ    [N][$];
  retFlit_t      retSendQ [$];
  retFlit_t      retExpQ  [$];

  int inPkt = 0, rem = 0, curLane = 0, rrPtr = 0, decided = -1, fwdXferCount = 0;

  bsg_manycore_wh_edge_concentrator_if #(.wh_flit_width_p(FW), .num_in_p(N)) link_if ();

  bsg_manycore_wh_edge_concentrator #(
    .wh_flit_width_p (FW),
    .wh_cid_width_p  (CIDW),
    .wh_len_width_p  (LENW),
    .wh_cord_width_p (CORDW),
    .num_in_p        (N)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .link_if (link_if)
  );

  always_comb begin
    for (int i = 0; i < N; i++) link_if.links_i[i] = {fwdV[i], fwdData[i], retRdy[i]};
  end
  assign link_if.concentrated_link_i = {retV, retData, concRdy};

  function automatic logic laneOutV(int i);
    return link_if.links_o[i][LW-1];
  endfunction

  function automatic logic laneOutRdy(int i);
    return link_if.links_o[i][0];
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    totalChecks++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [FW-1:0] mkHdr(int len, int cid);
    logic [FW-1:0] h;
    h = FW'($urandom);
    h[CORDW +: LENW] = LENW'(len);
    h[CORDW+LENW +: CIDW] = CIDW'(cid);
    return h;
  endfunction

  task automatic queueFwdPkt(input int lane, input int len);
    fwdSendQ[lane].push_back(mkHdr(len, $urandom_range(15, 0)));
    for (int b = 0; b < len; b++) fwdSendQ[lane].push_back(FW'($urandom));
  endtask

  task automatic queueRetPkt(input int cid, input int len);
    retFlit_t f;
    f.lane = 8'(cid);
    f.data = mkHdr(len, cid);
    retSendQ.push_back(f);
    for (int b = 0; b < len; b++) begin
      f.data = FW'($urandom);
      retSendQ.push_back(f);
    end
  endtask

  // Each accepted flit is pushed as an expectation right after the accepting edge
  task automatic applyStimulus(input int n);
    logic [N-1:0] acc;
    logic         accR;
    repeat (n) begin
      @(negedge clk_i);
      for (int i = 0; i < N; i++) acc[i] = fwdV[i] && laneOutRdy(i);
      accR = retV && link_if.concentrated_link_o[0];
      @(posedge clk_i);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) laneQ[i].push_back(fwdSendQ[i].pop_front());
        if (!fwdV[i] || acc[i]) begin
          fwdV[i] = (fwdSendQ[i].size() > 0) && ($urandom_range(99, 0) < fwdPct);
          fwdData[i] = fwdV[i] ? fwdSendQ[i][0] : '0;
        end
        retRdy[i] = ($urandom_range(99, 0) < laneRdyPct);
      end
      if (accR) retExpQ.push_back(retSendQ.pop_front());
      if (!retV || accR) begin
        retV = (retSendQ.size() > 0) && ($urandom_range(99, 0) < retPct);
        retData = retV ? retSendQ[0].data : '0;
      end
      concRdy = ($urandom_range(99, 0) < concPct);
    end
  endtask

  task automatic checkOutput();
    logic          cv;
    logic [FW-1:0] cd, flit;
    int            lane, expV, len;
    retFlit_t      rf;
    if (reset_i) begin
      for (int i = 0; i < N; i++) laneQ[i].delete();
      retExpQ.delete();
      inPkt = 0; rem = 0; curLane = 0; rrPtr = 0; decided = -1;
      return;
    end
    cv = link_if.concentrated_link_o[LW-1];
    cd = link_if.concentrated_link_o[LW-2:1];
    if (inPkt == 0 && decided < 0) begin
      for (int k = 0; k < N; k++) begin
        if (decided < 0 && laneQ[(rrPtr + k) % N].size() > 0) decided = (rrPtr + k) % N;
      end
    end
    lane = (inPkt != 0) ? curLane : decided;
    expV = (inPkt != 0) ? int'(laneQ[curLane].size() > 0) : int'(decided >= 0);
    check("fwd_v", 32'(cv), expV);
    if (cv && expV != 0) begin
      check("fwd_data", 32'(cd), 32'(laneQ[lane][0]));
      if (concRdy) begin
        flit = laneQ[lane].pop_front();
        fwdXferCount++;
        if (inPkt == 0) begin
          len = int'(flit[CORDW +: LENW]);
          if (len > 0) begin
            inPkt = 1; rem = len; curLane = lane;
          end else rrPtr = (lane + 1) % N;
          decided = -1;
        end else begin
          rem--;
          if (rem == 0) begin
            inPkt = 0; rrPtr = (curLane + 1) % N;
          end
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      check("ret_v", 32'(laneOutV(i)), 32'(retExpQ.size() > 0 && int'(retExpQ[0].lane) == i));
    end
    if (retExpQ.size() > 0) begin
      rf = retExpQ[0];
      if (laneOutV(int'(rf.lane))) begin
        check("ret_data", 32'(link_if.links_o[int'(rf.lane)][LW-2:1]), 32'(rf.data));
        if (retRdy[int'(rf.lane)]) retExpQ.pop_front();
      end
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk_i);
      checkOutput();
    end
  end

  function automatic int pendingWork();
    int s;
    s = retSendQ.size() + retExpQ.size() + int'(retV);
    for (int i = 0; i < N; i++) s += fwdSendQ[i].size() + laneQ[i].size() + int'(fwdV[i]);
    return s;
  endfunction

  initial begin : driver
    int base, budget;
    #2;
    check("rst_conc_v", 32'(link_if.concentrated_link_o[LW-1]), 0);
    check("rst_conc_rdy", 32'(link_if.concentrated_link_o[0]), 0);
    for (int i = 0; i < N; i++) begin
      check("rst_lane_v", 32'(laneOutV(i)), 0);
      check("rst_lane_rdy", 32'(laneOutRdy(i)), 0);
    end
    #10 reset_i = 1'b0;
    #1;
    check("post_rst_conc_rdy", 32'(link_if.concentrated_link_o[0]), 1);
    check("post_rst_lane_rdy", 32'(laneOutRdy(0)), 1);

    $display("[TB] single lane packet");
    queueFwdPkt(0, 3);
    applyStimulus(10);

    $display("[TB] simultaneous headers, round robin");
    for (int r = 0; r < 2; r++) begin
      queueFwdPkt(0, 2);
      queueFwdPkt(1, 2);
      applyStimulus(12);
    end

    $display("[TB] back-to-back zero-length headers");
    for (int r = 0; r < 3; r++) begin
      queueFwdPkt(0, 0);
      queueFwdPkt(1, 0);
    end
    applyStimulus(12);

    $display("[TB] return steering");
    queueRetPkt(1, 2);
    queueRetPkt(0, 1);
    applyStimulus(12);

    $display("[TB] output stall");
    concPct = 0;
    queueFwdPkt(0, 4);
    applyStimulus(4);
    check("stall_lane_rdy", 32'(laneOutRdy(0)), 0);
    check("stall_conc_v", 32'(link_if.concentrated_link_o[LW-1]), 1);
    concPct = 50;
    applyStimulus(30);

    $display("[TB] reset mid-packet");
    concPct = 100;
    queueFwdPkt(0, 4);
    base = fwdXferCount;
    budget = 40;
    while (fwdXferCount < base + 2 && budget > 0) begin
      applyStimulus(1);
      budget--;
    end
    check("rst_wait_xfers", 32'(fwdXferCount - base), 2);
    #2 reset_i = 1'b1;
    #1;
    check("mid_rst_conc_v", 32'(link_if.concentrated_link_o[LW-1]), 0);
    check("mid_rst_lane_rdy", 32'(laneOutRdy(0)), 0);
    for (int i = 0; i < N; i++) begin
      fwdSendQ[i].delete();
      check("mid_rst_lane_v", 32'(laneOutV(i)), 0);
    end
    retSendQ.delete();
    fwdV = '0;
    retV = 1'b0;
    repeat (2) @(negedge clk_i);
    #2 reset_i = 1'b0;
    queueFwdPkt(1, 1);
    applyStimulus(8);

    $display("[TB] random traffic");
    fwdPct = 70; concPct = 60; retPct = 70; laneRdyPct = 60;
    for (int it = 0; it < 80; it++) begin
      for (int i = 0; i < N; i++) begin
        if (fwdSendQ[i].size() < 4)
          queueFwdPkt(i, ($urandom_range(7, 0) == 0) ? 15 : $urandom_range(3, 0));
      end
      if (retSendQ.size() < 4)
        queueRetPkt($urandom_range(N - 1, 0), ($urandom_range(7, 0) == 0) ? 15 : $urandom_range(3, 0));
      applyStimulus(25);
    end

    fwdPct = 100; concPct = 100; retPct = 100; laneRdyPct = 100;
    budget = 400;
    while (pendingWork() > 0 && budget > 0) begin
      applyStimulus(1);
      budget--;
    end
    applyStimulus(2);
    check("drain_empty", 32'(pendingWork()), 0);

    $display("%0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end
endmodule

// File: doc/bsg_manycore_wh_edge_concentrator.md
Name: bsg_manycore_wh_edge_concentrator

Overview:
- Sits at the E or W edge of the pod array and attaches to the vcache wormhole links of one pod row and one N/S side.
- Forward path: merges the wh_ruche_factor_p wormhole links from that row and side into one wormhole link toward the memory/IO side.
- Return path: splits the single return link back to the correct ruche lane using the cid field of each packet header.
- Packets are never interleaved: once a packet starts, it owns the output until its last flit is transferred.

Parameters:
- wh_flit_width_p, none (required), flit width in bits.
- wh_cid_width_p, none (required), width of the cid field in the header.
- wh_len_width_p, none (required), width of the len field in the header.
- wh_cord_width_p, none (required), width of the destination-cord field in the header.
- num_in_p, 2, number of concentrated lanes; equals wh_ruche_factor_p; must be at least 2.
- lg_num_in_lp, localparam, `BSG_SAFE_CLOG2(num_in_p).
- wh_link_sif_width_lp, localparam, `bsg_ready_and_link_sif_width(wh_flit_width_p).

Ports:
- clk_i  in  1  Single clock for the whole block.
- reset_i  in  1  Asynchronous, active-high reset.
- links_i  in  [num_in_p-1:0][wh_link_sif_width_lp-1:0]  Lane-side link inputs: forward flits in, return ready_and_rev in.
- links_o  out  [num_in_p-1:0][wh_link_sif_width_lp-1:0]  Lane-side link outputs: return flits out, forward ready_and_rev out.
- concentrated_link_i  in  [wh_link_sif_width_lp-1:0]  Edge-side link input: return flits in, forward ready_and_rev in.
- concentrated_link_o  out  [wh_link_sif_width_lp-1:0]  Edge-side link output: forward flits out, return ready_and_rev out.

Behaviour:
- Link format: each link uses the standard ready-and link struct with fields {v, data, ready_and_rev}.
- A flit transfers on a cycle where v and the receiver's ready_and_rev are both 1.
- Header flit layout:
  - data[wh_cord_width_p-1:0] = destination cord.
  - Next wh_len_width_p bits = len, the number of non-header flits that follow.
  - Next wh_cid_width_p bits = cid.
- Input buffering: every input (each forward lane and the return link) goes into a 2-element FIFO.
  - The ready_and_rev driven back on a link is that FIFO's ready.
  - No combinational path exists from any ready input to any ready output.
- Forward path FSM, states IDLE and BUSY:
  - IDLE: round-robin arbiter looks at the FIFO heads of all lanes.
    - Priority starts at the lane after the last granted lane.
    - The grant is combinational: concentrated v = 1 with the granted head flit in the same cycle.
  - When the header transfers with len>0: latch the grant, load the counter with len, go to BUSY.
  - When the header transfers with len==0: stay IDLE and advance the round-robin pointer.
  - BUSY: forward only the latched lane.
    - Decrement the counter on each transferred flit.
    - The transfer that occurs with counter==1 returns the FSM to IDLE and advances the pointer.
    - Other lanes' FIFOs keep accepting flits but are not drained.
  - If the output is not ready, the head flit and the grant are held and stay stable.
- Return path FSM: same IDLE/BUSY structure.
  - The destination lane = the low lg_num_in_lp bits of cid, taken from the header.
  - Only the selected lane's links_o v is asserted; the others are 0.
  - The counter and the lane select are latched for the remainder of the packet.
  - A cid >= num_in_p raises a simulation-only assertion error.
- Counter width: wh_len_width_p. Maximum len, all ones, is fully supported.
- Reset values, all asynchronous:
  - Both FSMs in IDLE, both counters 0.
  - Round-robin pointer gives lane 0 the first priority.
  - FIFOs empty.
  - All v outputs 0; all ready_and_rev outputs 0 while reset_i is high.
- Reset mid-packet: the partially forwarded packet is dropped. After deassertion the first accepted flit on any link is treated as a header.
- Forward and return paths are fully independent and may transfer in the same cycle.

Test Plan:
- Lane 0 sends header len=3 plus 3 body flits; concentrated ready held at 1 -> 4 flits appear in order on consecutive cycles; FSM ends IDLE.
- Lanes 0 and 1 present headers (len=2) in the same cycle -> lane 0 packet fully (3 flits), then lane 1 packet fully (3 flits); no interleaving; next tie grants lane 0 again.
- Lane 1 sends three back-to-back len=0 headers while lane 0 is also sending len=0 headers -> output alternates 0,1,0,1...; one header per cycle.
- Return header cid=1, len=2 -> 3 flits on links_o[1]; links_o[0] v stays 0. Next header cid=0 -> delivered on lane 0.
- Concentrated ready toggles 1,0,0,1 during a len=4 packet -> data held stable while stalled; no flit lost or duplicated; lane FIFO ready deasserts after 2 buffered flits.
- reset_i asserted asynchronously after 2 of 5 flits -> all v outputs drop to 0 immediately. After release, a new len=1 header from lane 1 is forwarded correctly.
